// File: rtl/chan_select_packetizer.sv
// chan_select_packetizer: bin-mask channel selector feeding a packetizer.
// Optional statistics counters are enabled by defining CHAN_SEL_STATS_EN.

module chan_select_packetizer #(
    parameter int DATA_W       = 32,
    parameter int FFT_MAX_LOG2 = 11,
    parameter int PKT_W        = 16
) (
    input  logic                    clk,
    input  logic                    sync_reset,
    input  logic [PKT_W-1:0]        pkt_len,
    input  logic [DATA_W-1:0]       s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [FFT_MAX_LOG2-1:0] s_axis_tuser,
    input  logic                    s_axis_teob,
    input  logic [31:0]             s_axis_select_tdata,
    input  logic                    s_axis_select_tvalid,
    output logic                    s_axis_select_tready,
    input  logic                    s_axis_select_tlast,
    output logic [DATA_W-1:0]       m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    m_axis_teob,
    output logic [31:0]             stat_frames,
    output logic [31:0]             stat_samples
);

    localparam int WP_W  = FFT_MAX_LOG2 - 5;
    localparam int DEPTH = 1 << WP_W;

    logic [31:0]       mask_q [2][DEPTH];
    logic              active_q, active_d;
    logic              mask_valid_q, mask_valid_d;
    logic              swap_pending_q, swap_pending_d;
    logic              in_frame_q, in_frame_d;
    logic              eob_pending_q, eob_pending_d;
    logic [WP_W-1:0]   wp_q, wp_d;
    logic [PKT_W-1:0]  cnt_q, cnt_d;
    logic [PKT_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              teob_q, teob_d;

    logic              in_acc, sel_acc;
    logic              idle_swap, do_swap;
    logic              look_bank, look_valid;
    logic [31:0]       mask_word;
    logic              mask_bit, pass;
    logic [PKT_W-1:0]  eff_len, cur_len;
    logic              eob_now, end_pkt;

    assign s_axis_tready        = !valid_q || m_axis_tready;
    assign s_axis_select_tready = !swap_pending_q;
    assign in_acc  = s_axis_tvalid && s_axis_tready;
    assign sel_acc = s_axis_select_tvalid && s_axis_select_tready;

    // An idle swap takes effect at this edge, so a frame starting now
    // must already look up the incoming bank.
    assign idle_swap  = swap_pending_q && !in_frame_q;
    assign do_swap    = swap_pending_q
                        && (!in_frame_q || (in_acc && s_axis_tlast));
    assign look_bank  = active_q ^ idle_swap;
    assign look_valid = mask_valid_q || idle_swap;
    assign mask_word  = mask_q[look_bank][s_axis_tuser[FFT_MAX_LOG2-1:5]];
    assign mask_bit   = mask_word[s_axis_tuser[4:0]];
    assign pass       = in_acc && (!look_valid || mask_bit);

    assign eff_len = (pkt_len == '0) ? PKT_W'(1) : pkt_len;
    assign cur_len = (cnt_q == '0) ? eff_len : len_q;
    assign eob_now = s_axis_teob || eob_pending_q;
    assign end_pkt = (cnt_q == cur_len - PKT_W'(1)) || eob_now;

    // Next-state for output register, packet counter and mask control.
    always_comb begin
        valid_d        = valid_q;
        data_d         = data_q;
        last_d         = last_q;
        teob_d         = teob_q;
        cnt_d          = cnt_q;
        len_d          = len_q;
        eob_pending_d  = eob_pending_q;
        in_frame_d     = in_frame_q;
        wp_d           = wp_q;
        swap_pending_d = swap_pending_q;
        active_d       = active_q;
        mask_valid_d   = mask_valid_q;
        if (s_axis_tready) begin
            valid_d = pass;
        end
        if (pass) begin
            data_d        = s_axis_tdata;
            last_d        = end_pkt;
            teob_d        = eob_now;
            len_d         = cur_len;
            cnt_d         = end_pkt ? '0 : cnt_q + PKT_W'(1);
            eob_pending_d = 1'b0;
        end else if (in_acc && s_axis_teob) begin
            eob_pending_d = 1'b1;
        end
        if (in_acc) begin
            in_frame_d = !s_axis_tlast;
        end
        if (sel_acc) begin
            wp_d = s_axis_select_tlast ? '0 : wp_q + WP_W'(1);
            swap_pending_d = s_axis_select_tlast;
        end
        if (do_swap) begin
            active_d       = !active_q;
            mask_valid_d   = 1'b1;
            swap_pending_d = 1'b0;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            valid_q        <= 1'b0;
            data_q         <= '0;
            last_q         <= 1'b0;
            teob_q         <= 1'b0;
            cnt_q          <= '0;
            len_q          <= '0;
            eob_pending_q  <= 1'b0;
            in_frame_q     <= 1'b0;
            wp_q           <= '0;
            swap_pending_q <= 1'b0;
            active_q       <= 1'b0;
            mask_valid_q   <= 1'b0;
        end else begin
            valid_q        <= valid_d;
            data_q         <= data_d;
            last_q         <= last_d;
            teob_q         <= teob_d;
            cnt_q          <= cnt_d;
            len_q          <= len_d;
            eob_pending_q  <= eob_pending_d;
            in_frame_q     <= in_frame_d;
            wp_q           <= wp_d;
            swap_pending_q <= swap_pending_d;
            active_q       <= active_d;
            mask_valid_q   <= mask_valid_d;
        end
    end

    // Mask loads always land in the shadow bank.
    always_ff @(posedge clk) begin
        if (sel_acc) begin
            mask_q[!active_q][wp_q] <= s_axis_select_tdata;
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = valid_q;
    assign m_axis_tlast  = last_q;
    assign m_axis_teob   = teob_q;

`ifdef CHAN_SEL_STATS_EN
    logic [31:0] frames_q;
    logic [31:0] samples_q;

    // Count input frames and output handshakes, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            frames_q  <= '0;
            samples_q <= '0;
        end else begin
            if (in_acc && s_axis_tlast) begin
                frames_q <= frames_q + 32'd1;
            end
            if (valid_q && m_axis_tready) begin
                samples_q <= samples_q + 32'd1;
            end
        end
    end

    assign stat_frames  = frames_q;
    assign stat_samples = samples_q;
`else
    assign stat_frames  = '0;
    assign stat_samples = '0;
`endif

endmodule

// File: tb/tb_chan_select_packetizer.sv
// Directed bench for chan_select_packetizer.
// Expected outputs are hand-derived per test step.

module tb_chan_select_packetizer;

    localparam int DW = 32;
    localparam int FL = 11;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          sync_reset;
    logic [PW-1:0] pkt_len;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [FL-1:0] s_axis_tuser;
    logic          s_axis_teob;
    logic [31:0]   s_axis_select_tdata;
    logic          s_axis_select_tvalid;
    logic          s_axis_select_tready;
    logic          s_axis_select_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          m_axis_teob;
    logic [31:0]   stat_frames;
    logic [31:0]   stat_samples;

    int checks   = 0;
    int failures = 0;
    logic [DW+1:0] got_q[$];
    logic [DW+1:0] exp_q[$];
    logic          rnd_en = 1'b0;
    logic          hold_v = 1'b0;
    logic [DW+1:0] hold_d = '0;

    always #5 clk = ~clk;

    chan_select_packetizer #(
        .DATA_W(DW), .FFT_MAX_LOG2(FL), .PKT_W(PW)
    ) dut (
        .clk(clk),
        .sync_reset(sync_reset),
        .pkt_len(pkt_len),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast),
        .s_axis_tuser(s_axis_tuser),
        .s_axis_teob(s_axis_teob),
        .s_axis_select_tdata(s_axis_select_tdata),
        .s_axis_select_tvalid(s_axis_select_tvalid),
        .s_axis_select_tready(s_axis_select_tready),
        .s_axis_select_tlast(s_axis_select_tlast),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_teob(m_axis_teob),
        .stat_frames(stat_frames),
        .stat_samples(stat_samples)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: collects handshakes, checks hold under backpressure.
    always @(negedge clk) begin
        if (sync_reset) begin
            hold_v <= 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold", {m_axis_tvalid, m_axis_tlast, m_axis_teob,
                    m_axis_tdata}, {1'b1, hold_d});
            end
            if (m_axis_tvalid && m_axis_tready) begin
                got_q.push_back({m_axis_tlast, m_axis_teob, m_axis_tdata});
            end
            hold_v <= m_axis_tvalid && !m_axis_tready;
            hold_d <= {m_axis_tlast, m_axis_teob, m_axis_tdata};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_en) m_axis_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [DW-1:0] d, input int bin,
                        input logic last, input logic eob);
        int n;
        n = 0;
        s_axis_tdata  = d;
        s_axis_tuser  = FL'(bin);
        s_axis_tlast  = last;
        s_axis_teob   = eob;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        while (!s_axis_tready && n < 200) begin
            tick();
            @(negedge clk);
            n++;
        end
        if (!s_axis_tready) begin
            checks++;
            failures++;
            $error("FAIL send_timeout observed=stalled expected=ready");
        end
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_teob   = 1'b0;
    endtask

    task automatic load(input logic [31:0] d, input logic last);
        int n;
        n = 0;
        s_axis_select_tdata  = d;
        s_axis_select_tlast  = last;
        s_axis_select_tvalid = 1'b1;
        @(negedge clk);
        while (!s_axis_select_tready && n < 200) begin
            tick();
            @(negedge clk);
            n++;
        end
        if (!s_axis_select_tready) begin
            checks++;
            failures++;
            $error("FAIL load_timeout observed=stalled expected=ready");
        end
        tick();
        s_axis_select_tvalid = 1'b0;
        s_axis_select_tlast  = 1'b0;
    endtask

    task automatic do_reset();
        sync_reset = 1'b1;
        tick();
        tick();
        sync_reset = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic expect_out(input logic last, input logic eob,
                              input logic [DW-1:0] d);
        exp_q.push_back({last, eob, d});
    endtask

    task automatic compare(input string tag);
        int n;
        chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk(tag, 64'(got_q[i]), 64'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [DW-1:0] d;
        sync_reset           = 1'b1;
        pkt_len              = PW'(4);
        s_axis_tdata         = '0;
        s_axis_tvalid        = 1'b0;
        s_axis_tlast         = 1'b0;
        s_axis_tuser         = '0;
        s_axis_teob          = 1'b0;
        s_axis_select_tdata  = '0;
        s_axis_select_tvalid = 1'b0;
        s_axis_select_tlast  = 1'b0;
        m_axis_tready        = 1'b1;
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("rst_tlast", 64'(m_axis_tlast), 64'(0));
        chk("rst_teob", 64'(m_axis_teob), 64'(0));
        chk("rst_sel_rdy", 64'(s_axis_select_tready), 64'(1));
        chk("rst_in_rdy", 64'(s_axis_tready), 64'(1));
        chk("rst_frames", 64'(stat_frames), 64'(0));
        chk("rst_samples", 64'(stat_samples), 64'(0));
        tick();

        // No mask: 8 bins, pkt_len 4 -> two packets
        for (int i = 0; i < 8; i++) begin
            send(DW'(32'h100 + i), i, i == 7, 1'b0);
            expect_out(i == 3 || i == 7, 1'b0, DW'(32'h100 + i));
        end
        idle(3);
        compare("pass_all");

        // Load 0xA5 mid-frame; second load stalls until frame end
        for (int i = 0; i < 3; i++) begin
            send(DW'(32'h200 + i), i, 1'b0, 1'b0);
        end
        load(32'h0000_00A5, 1'b1);
        @(negedge clk);
        chk("sel_rdy_pend", 64'(s_axis_select_tready), 64'(0));
        tick();
        s_axis_select_tdata  = 32'h0000_000F;
        s_axis_select_tlast  = 1'b1;
        s_axis_select_tvalid = 1'b1;
        for (int i = 3; i < 7; i++) begin
            send(DW'(32'h200 + i), i, 1'b0, 1'b0);
        end
        @(negedge clk);
        chk("sel_rdy_infrm", 64'(s_axis_select_tready), 64'(0));
        tick();
        send(DW'(32'h207), 7, 1'b1, 1'b0);
        @(negedge clk);
        chk("sel_rdy_after", 64'(s_axis_select_tready), 64'(1));
        s_axis_select_tvalid = 1'b0;
        s_axis_select_tlast  = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            expect_out(i == 3 || i == 7, 1'b0, DW'(32'h200 + i));
        end
        for (int i = 0; i < 8; i++) begin
            send(DW'(32'h300 + i), i, i == 7, 1'b0);
        end
        expect_out(1'b0, 1'b0, DW'(32'h300));
        expect_out(1'b0, 1'b0, DW'(32'h302));
        expect_out(1'b0, 1'b0, DW'(32'h305));
        expect_out(1'b1, 1'b0, DW'(32'h307));
        idle(3);
        compare("mask_a5");

        // teob on deselected bin 3, pkt_len 10, then short lengths
        do_reset();
        pkt_len = PW'(10);
        load(32'h0000_00F7, 1'b1);
        for (int i = 0; i < 8; i++) begin
            send(DW'(32'h400 + i), i, i == 7, i == 3);
        end
        for (int i = 0; i < 8; i++) begin
            send(DW'(32'h500 + i), i, i == 7, 1'b0);
        end
        expect_out(1'b0, 1'b0, DW'(32'h400));
        expect_out(1'b0, 1'b0, DW'(32'h401));
        expect_out(1'b0, 1'b0, DW'(32'h402));
        expect_out(1'b1, 1'b1, DW'(32'h404));
        expect_out(1'b0, 1'b0, DW'(32'h405));
        expect_out(1'b0, 1'b0, DW'(32'h406));
        expect_out(1'b0, 1'b0, DW'(32'h407));
        expect_out(1'b0, 1'b0, DW'(32'h500));
        expect_out(1'b0, 1'b0, DW'(32'h501));
        expect_out(1'b0, 1'b0, DW'(32'h502));
        expect_out(1'b0, 1'b0, DW'(32'h504));
        expect_out(1'b0, 1'b0, DW'(32'h505));
        expect_out(1'b0, 1'b0, DW'(32'h506));
        expect_out(1'b1, 1'b0, DW'(32'h507));
        pkt_len = PW'(2);
        send(DW'(32'h600), 0, 1'b0, 1'b0);
        send(DW'(32'h601), 1, 1'b0, 1'b1);
        pkt_len = PW'(0);
        send(DW'(32'h602), 2, 1'b0, 1'b0);
        send(DW'(32'h604), 4, 1'b1, 1'b0);
        expect_out(1'b0, 1'b0, DW'(32'h600));
        expect_out(1'b1, 1'b1, DW'(32'h601));
        expect_out(1'b1, 1'b0, DW'(32'h602));
        expect_out(1'b1, 1'b0, DW'(32'h604));
        idle(3);
        compare("eob");

        // Random backpressure, 1000 samples, no mask, pkt_len 5
        do_reset();
        pkt_len = PW'(5);
        rnd_en  = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            d = DW'($urandom);
            send(d, k % 8, (k % 8) == 7, 1'b0);
            expect_out((k % 5) == 4, 1'b0, d);
        end
        rnd_en        = 1'b0;
        m_axis_tready = 1'b1;
        idle(5);
        compare("rand");

        // Statistics: 3 frames of 8 bins, mask 0x0F
        do_reset();
        pkt_len = PW'(4);
        load(32'h0000_000F, 1'b1);
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) begin
                send(DW'(32'h700 + 16 * f + i), i, i == 7, 1'b0);
                if (i < 4) begin
                    expect_out(i == 3, 1'b0, DW'(32'h700 + 16 * f + i));
                end
            end
        end
        idle(3);
        compare("stats_data");
        @(negedge clk);
`ifdef CHAN_SEL_STATS_EN
        chk("stat_frames", 64'(stat_frames), 64'(3));
        chk("stat_samples", 64'(stat_samples), 64'(12));
`else
        chk("stat_frames", 64'(stat_frames), 64'(0));
        chk("stat_samples", 64'(stat_samples), 64'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chan_select_packetizer.md
CHAN_SELECT_PACKETIZER -- requirements
Module: chan_select_packetizer

Interface
REQ-001 Parameter DATA_W, default 32, sample width (I/Q packed).
REQ-002 Parameter FFT_MAX_LOG2, default 11, log2 of maximum bins per frame; mask depth 2^FFT_MAX_LOG2/32 words per bank.
REQ-003 Parameter PKT_W, default 16, width of pkt_len and the packet word counter.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 sync_reset  in  1  reset, synchronous, active-high.
REQ-006 pkt_len  in  PKT_W  output packet length in samples; 0 treated as 1.
REQ-007 s_axis_tdata/tvalid/tready/tlast  in/in/out/in  DATA_W/1/1/1  channelized samples; tlast marks the final bin of an FFT frame.
REQ-008 s_axis_tuser  in  FFT_MAX_LOG2  bin index of the current sample.
REQ-009 s_axis_teob  in  1  end-of-burst flag, qualified by tvalid.
REQ-010 s_axis_select_tdata/tvalid/tready/tlast  in/in/out/in  32/1/1/1  mask load stream; word k bit j selects bin 32k+j; tlast ends a load.
REQ-011 m_axis_tdata/tvalid/tready/tlast  out/out/in/out  DATA_W/1/1/1  selected, packetized samples.
REQ-012 m_axis_teob  out  1  end-of-burst, valid with m_axis_tlast.
REQ-013 stat_frames, stat_samples  out  32 each  statistics counters (see Configuration).

Function
REQ-014 Output stage is one register; latency from input handshake to m_axis_tvalid is 1 cycle.
REQ-015 s_axis_tready = !m_axis_tvalid || m_axis_tready; deselected samples are consumed under the same condition and never reach the output.
REQ-016 An accepted sample is selected when the active mask bank bit at s_axis_tuser is 1, or when no mask load has ever completed (mask_valid = 0).
REQ-017 Mask storage is two banks (active, shadow); loads write the shadow bank at write pointer wp, and wp increments per accepted select word.
REQ-018 wp wraps modulo bank depth; wp clears to 0 on an accepted select word with tlast, which also sets swap_pending.
REQ-019 s_axis_select_tready = !swap_pending; a second load stalls until the swap occurs.
REQ-020 The swap (toggle active bank, set mask_valid, clear swap_pending) happens on the cycle after an input sample with s_axis_tlast is accepted, or immediately when swap_pending and in_frame = 0.
REQ-021 in_frame is set on any accepted input sample and cleared on an accepted sample with tlast; a mask never changes mid-frame.
REQ-022 Packet counter cnt latches the effective pkt_len on the first selected sample of each packet; pkt_len changes mid-packet take effect at the next packet.
REQ-023 m_axis_tlast is set when cnt = latched length - 1, or when eob applies; cnt then returns to 0.
REQ-024 eob_pending is set by an accepted sample with s_axis_teob; it applies to that sample if selected, otherwise to the next selected sample; that sample carries tlast = 1, teob = 1, and clears eob_pending.
REQ-025 Simultaneous length-end and eob produce a single tlast with teob = 1.
REQ-026 Output data, tlast and teob hold stable while m_axis_tvalid = 1 and m_axis_tready = 0.

Reset
REQ-027 On sync_reset: m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_teob = 0, cnt = 0, wp = 0, swap_pending = 0, mask_valid = 0, in_frame = 0, eob_pending = 0, active bank = 0, stat counters = 0.
REQ-028 Reset mid-packet or mid-load discards the partial packet and partial mask; bank contents need not be cleared.

Configuration
REQ-029 Macro CHAN_SEL_STATS_EN: when defined, stat_frames counts accepted input frames (tlast), and stat_samples counts output handshakes; both wrap at 2^32.
REQ-030 When CHAN_SEL_STATS_EN is not defined, stat_frames and stat_samples are constant 0 and no counter logic is synthesized.

Verification
REQ-031 No mask loaded, pkt_len = 4, 8 bins per frame -> 2 packets of 4 samples, with tlast on samples 4 and 8, and data unchanged.
REQ-032 Load one word 0x0000_00A5 (tlast) mid-frame -> the current frame passes all bins; the next frame outputs only bins 0, 2, 5, 7.
REQ-033 Second load issued before the swap -> s_axis_select_tready = 0 until the cycle after the frame tlast, then 1.
REQ-034 pkt_len = 10, teob on a deselected bin 3 -> the next selected bin outputs tlast = 1 and teob = 1, and the following packet restarts with cnt = 0.
REQ-035 m_axis_tready toggling 50% random over 1000 samples -> no loss or duplication, and output matches the reference model.
REQ-036 With CHAN_SEL_STATS_EN, 3 frames of 8 bins with mask 0x0F -> stat_frames = 3 and stat_samples = 12; without the macro, both read 0.
